// File: rtl/aes128_key_schedule_if.sv
// Handshake, round-key stream and table read port of the AES-128 key schedule.
interface aes128_key_schedule_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;

    modport master (
        output start, key_in, rd_idx,
        input  busy, rk_valid, rk_idx, round_key, done, keys_ready, rd_data
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, rk_valid, rk_idx, round_key, done, keys_ready, rd_data
    );
endinterface

// File: rtl/aes128_key_schedule.sv
// Sequential AES-128 forward key expansion: one round key per clock, streamed
// out and stored in an 11-entry table with a registered random-access read port.
module aes128_ks_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[{a_i, 3'b000} +: 8];
endmodule

module aes128_key_schedule #(
    parameter int NROUNDS = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    aes128_key_schedule_if.slave ks
);
    typedef enum logic {IDLE, EXPAND} state_e;

    localparam logic [3:0] LAST = 4'(NROUNDS);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q, rk_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ready_q, ready_d;
    logic         wr_en;
    logic [127:0] rd_q;
    logic [127:0] tbl_q [0:NROUNDS];

    logic [3:0]   nxt;
    logic [7:0]   rcon;
    logic [31:0]  rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;

    assign nxt = cnt_q + 4'd1;

    always_comb begin
        case (nxt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord of w3 (the low word), then SubWord through four shared S-boxes
    assign rot = {rk_q[23:0], rk_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes128_ks_sbox u_sbox (
            .a_i (rot[8*i +: 8]),
            .y_o (sub[8*i +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h000000};
    assign n0 = rk_q[127:96] ^ t;
    assign n1 = rk_q[95:64]  ^ n0;
    assign n2 = rk_q[63:32]  ^ n1;
    assign n3 = rk_q[31:0]   ^ n2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    state_d = EXPAND;
                    cnt_d   = '0;
                    rk_d    = ks.key_in;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    wr_en   = 1'b1;
                end
            end
            EXPAND: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d   = nxt;
                    rk_d    = {n0, n1, n2, n3};
                    valid_d = 1'b1;
                    wr_en   = 1'b1;
                    done_d  = (nxt == LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rk_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rk_q    <= rk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Table entry index follows the round counter; contents are not reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tbl_q[cnt_d] <= rk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (ks.rd_idx <= LAST) begin
            rd_q <= tbl_q[ks.rd_idx];
        end else begin
            rd_q <= '0;
        end
    end

    assign ks.busy       = busy_q;
    assign ks.rk_valid   = valid_q;
    assign ks.rk_idx     = cnt_q;
    assign ks.round_key  = rk_q;
    assign ks.done       = done_q;
    assign ks.keys_ready = ready_q;
    assign ks.rd_data    = rd_q;
endmodule

// File: tb/tb_aes128_key_schedule.sv
// Directed bench for aes128_key_schedule using FIPS-197 and all-zero key vectors.
module tb_aes128_key_schedule;
    logic clk = 1'b0;
    logic rst_n;

    aes128_key_schedule_if ks ();

    aes128_key_schedule #(.NROUNDS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] got [0:10];
    int           valid_cnt, valid_first, valid_last;
    int           done_cnt, done_cyc, ready_cyc, busy_late;
    logic         ready13;
    logic [127:0] rk13, rk_last;
    logic [3:0]   idx_last;

    task automatic pulse_start(input logic [127:0] key);
        @(negedge clk);
        ks.key_in = key;
        ks.start  = 1'b1;
        @(negedge clk);
        ks.start  = 1'b0;
    endtask

    // Observes cycles T+1..T+14 after a start pulse; mode 1 re-asserts start
    // mid-expansion, mode 2 issues a FIPS start in the first IDLE cycle.
    task automatic collect(input int mode);
        valid_cnt = 0; valid_first = -1; valid_last = -1;
        done_cnt = 0; done_cyc = -1; ready_cyc = -1; busy_late = 0;
        for (int i = 0; i <= 10; i++) got[i] = '0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 12 || mode != 2) begin
                if (ks.rk_valid) begin
                    valid_cnt++;
                    if (valid_first < 0) valid_first = c;
                    valid_last = c;
                    if (c <= 11 && ks.rk_idx <= 4'd10) got[ks.rk_idx] = ks.round_key;
                end
                if (ks.done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = c;
                end
                if (ks.keys_ready && ready_cyc < 0) ready_cyc = c;
                if (c >= 12 && ks.busy) busy_late++;
            end
            if (c == 13) begin
                ready13 = ks.keys_ready;
                rk13    = ks.round_key;
            end
            if (c == 14) begin
                idx_last = ks.rk_idx;
                rk_last  = ks.round_key;
            end
            ks.start = (mode == 1 && (c == 3 || c == 7)) || (mode == 2 && c == 12);
            if (ks.start) ks.key_in = (mode == 1) ? 128'h0 : FIPS_KEY;
        end
        ks.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ks.start = 1'b0; ks.key_in = '0; ks.rd_idx = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (ks.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", ks.busy); end
        n_checks++; if (ks.rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got %b exp 0", ks.rk_valid); end
        n_checks++; if (ks.rk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_rk_idx got %0d exp 0", ks.rk_idx); end
        n_checks++; if (ks.round_key !== 128'h0) begin n_fail++; $display("FAIL reset_round_key got %h exp 0", ks.round_key); end
        n_checks++; if (ks.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", ks.done); end
        n_checks++; if (ks.keys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_keys_ready got %b exp 0", ks.keys_ready); end
        n_checks++; if (ks.rd_data !== 128'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", ks.rd_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        pulse_start(FIPS_KEY);
        collect(0);
        for (int r = 0; r <= 10; r++) begin
            n_checks++;
            if (got[r] !== FIPS_RK[r]) begin n_fail++; $display("FAIL fips_rk%0d got %h exp %h", r, got[r], FIPS_RK[r]); end
        end
        n_checks++; if (done_cyc != 11) begin n_fail++; $display("FAIL fips_done_cycle got %0d exp 11", done_cyc); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL fips_done_count got %0d exp 1", done_cnt); end
        n_checks++; if (ready_cyc != 12) begin n_fail++; $display("FAIL fips_ready_cycle got %0d exp 12", ready_cyc); end
        n_checks++; if (valid_cnt != 11) begin n_fail++; $display("FAIL fips_valid_count got %0d exp 11", valid_cnt); end
        n_checks++; if (valid_first != 1) begin n_fail++; $display("FAIL fips_valid_first got %0d exp 1", valid_first); end
        n_checks++; if (busy_late != 0) begin n_fail++; $display("FAIL fips_busy_after got %0d exp 0", busy_late); end
        n_checks++; if (idx_last !== 4'd10) begin n_fail++; $display("FAIL fips_idx_hold got %0d exp 10", idx_last); end
        n_checks++; if (rk_last !== FIPS_RK[10]) begin n_fail++; $display("FAIL fips_key_hold got %h exp %h", rk_last, FIPS_RK[10]); end
    endtask

    task automatic test_read_sweep();
        logic [127:0] exp;
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (k <= 10) ? (10 - k) : k;
            @(negedge clk);
            ks.rd_idx = 4'(idx);
            @(negedge clk);
            exp = (idx <= 10) ? FIPS_RK[idx] : 128'h0;
            n_checks++;
            if (ks.rd_data !== exp) begin n_fail++; $display("FAIL read_idx%0d got %h exp %h", idx, ks.rd_data, exp); end
        end
        ks.rd_idx = '0;
    endtask

    task automatic test_zero_key();
        pulse_start(128'h0);
        collect(0);
        n_checks++; if (got[0] !== 128'h0) begin n_fail++; $display("FAIL zero_rk0 got %h exp 0", got[0]); end
        n_checks++; if (got[1] !== ZERO_R1) begin n_fail++; $display("FAIL zero_rk1 got %h exp %h", got[1], ZERO_R1); end
        n_checks++; if (got[10] !== ZERO_R10) begin n_fail++; $display("FAIL zero_rk10 got %h exp %h", got[10], ZERO_R10); end
        n_checks++; if (valid_cnt != 11) begin n_fail++; $display("FAIL zero_valid_count got %0d exp 11", valid_cnt); end
        n_checks++; if (valid_first != 1) begin n_fail++; $display("FAIL zero_valid_first got %0d exp 1", valid_first); end
        n_checks++; if (valid_last != 11) begin n_fail++; $display("FAIL zero_valid_last got %0d exp 11", valid_last); end
    endtask

    task automatic test_start_while_busy();
        pulse_start(FIPS_KEY);
        collect(1);
        for (int r = 0; r <= 10; r++) begin
            n_checks++;
            if (got[r] !== FIPS_RK[r]) begin n_fail++; $display("FAIL busy_start_rk%0d got %h exp %h", r, got[r], FIPS_RK[r]); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d exp 1", done_cnt); end
        n_checks++; if (busy_late != 0) begin n_fail++; $display("FAIL busy_start_restart got %0d exp 0", busy_late); end
        @(negedge clk); ks.rd_idx = 4'd3;
        @(negedge clk);
        n_checks++; if (ks.rd_data !== FIPS_RK[3]) begin n_fail++; $display("FAIL busy_start_tbl3 got %h exp %h", ks.rd_data, FIPS_RK[3]); end
        ks.rd_idx = 4'd10;
        @(negedge clk);
        n_checks++; if (ks.rd_data !== FIPS_RK[10]) begin n_fail++; $display("FAIL busy_start_tbl10 got %h exp %h", ks.rd_data, FIPS_RK[10]); end
        ks.rd_idx = '0;
    endtask

    task automatic test_reset_mid();
        pulse_start(FIPS_KEY);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({ks.busy, ks.rk_valid, ks.done, ks.keys_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_flags got %b exp 0000", {ks.busy, ks.rk_valid, ks.done, ks.keys_ready}); end
        n_checks++; if (ks.round_key !== 128'h0 || ks.rk_idx !== 4'd0) begin
            n_fail++; $display("FAIL midrst_stream got %h/%0d exp 0/0", ks.round_key, ks.rk_idx); end
        n_checks++; if (ks.rd_data !== 128'h0) begin n_fail++; $display("FAIL midrst_rd_data got %h exp 0", ks.rd_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ks.keys_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_after got %b exp 0", ks.keys_ready); end
        pulse_start(FIPS_KEY);
        collect(0);
        n_checks++; if (ready_cyc != 12) begin n_fail++; $display("FAIL midrst_ready_cycle got %0d exp 12", ready_cyc); end
        n_checks++; if (done_cyc != 11) begin n_fail++; $display("FAIL midrst_done_cycle got %0d exp 11", done_cyc); end
        for (int r = 0; r <= 10; r++) begin
            n_checks++;
            if (got[r] !== FIPS_RK[r]) begin n_fail++; $display("FAIL midrst_rk%0d got %h exp %h", r, got[r], FIPS_RK[r]); end
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        pulse_start(128'h0);
        collect(2);
        n_checks++; if (got[10] !== ZERO_R10) begin n_fail++; $display("FAIL b2b_zero_rk10 got %h exp %h", got[10], ZERO_R10); end
        n_checks++; if (ready_cyc != 12) begin n_fail++; $display("FAIL b2b_ready_cycle got %0d exp 12", ready_cyc); end
        n_checks++; if (ready13 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop got %b exp 0", ready13); end
        n_checks++; if (rk13 !== FIPS_KEY) begin n_fail++; $display("FAIL b2b_rk0 got %h exp %h", rk13, FIPS_KEY); end
        waited = 0;
        while (!ks.done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++; if (ks.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_timeout got %b exp 1", ks.done); end
        @(negedge clk);
        n_checks++; if (ks.keys_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", ks.keys_ready); end
        ks.rd_idx = 4'd10;
        @(negedge clk);
        n_checks++; if (ks.rd_data !== FIPS_RK[10]) begin n_fail++; $display("FAIL b2b_tbl10 got %h exp %h", ks.rd_data, FIPS_RK[10]); end
        ks.rd_idx = '0;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_read_sweep();
        test_zero_key();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
